// File: rtl/shift_exec_stage.sv
// Two-stage pipelined shift unit: coarse byte-granular shift in stage 1,
// fine 0..7-bit shift in stage 2, valid/ready handshakes on both sides.
module shift_exec_stage #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned TAG_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_err,
    output logic               busy
);

    localparam int unsigned FINE_W = 3;
    localparam logic [1:0]  OP_SLL = 2'b00;
    localparam logic [1:0]  OP_SRL = 2'b01;
    localparam logic [1:0]  OP_SRA = 2'b10;

    // Shared shifter; the illegal op passes data through untouched.
    function automatic logic [WIDTH-1:0] do_shift(
        input logic [1:0]         op,
        input logic [WIDTH-1:0]   d,
        input logic [SHAMT_W-1:0] amt
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_SLL:  r = d << amt;
            OP_SRL:  r = d >> amt;
            OP_SRA:  r = WIDTH'($signed(d) >>> amt);
            default: r = d;
        endcase
        return r;
    endfunction

    // Stage 1 state
    logic               s1_valid;
    logic [WIDTH-1:0]   s1_data;
    logic [FINE_W-1:0]  s1_fine;
    logic [1:0]         s1_op;
    logic [TAG_W-1:0]   s1_tag;
    logic               s1_err;

    // Stage 2 state (drives the output payload directly)
    logic               s2_valid;

    logic               s1_adv;
    logic               accept;
    logic [SHAMT_W-1:0] shamt;
    logic [SHAMT_W-1:0] coarse_amt;
    logic [WIDTH-1:0]   coarse_data;
    logic [WIDTH-1:0]   fine_data;
    logic               unused_b_hi;

    // Only the low shift-amount bits of in_b matter; the rest are ignored.
    assign unused_b_hi = ^in_b[WIDTH-1:SHAMT_W];

    // Handshake control: stage 1 can advance when stage 2 is empty or draining.
    always_comb begin
        s1_adv   = s1_valid && (!s2_valid || out_ready);
        in_ready = !rst && !flush && (!s1_valid || s1_adv);
        accept   = in_valid && in_ready;
    end

    // Coarse shift by the upper shift-amount bits, in multiples of 8.
    always_comb begin
        shamt       = in_b[SHAMT_W-1:0];
        coarse_amt  = {shamt[SHAMT_W-1:FINE_W], FINE_W'(0)};
        coarse_data = do_shift(in_op, in_a, coarse_amt);
    end

    // Fine shift of stage-1 data; sign bit survives the coarse stage for SRA.
    always_comb begin
        fine_data = do_shift(s1_op, s1_data, SHAMT_W'(s1_fine));
    end

    // Stage 1 valid and payload registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_fine  <= '0;
            s1_op    <= OP_SLL;
            s1_tag   <= '0;
            s1_err   <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_data  <= coarse_data;
                s1_fine  <= shamt[FINE_W-1:0];
                s1_op    <= in_op;
                s1_tag   <= in_tag;
                s1_err   <= (in_op == 2'b11);
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2 valid and output payload registers; payload holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_err    <= 1'b0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else begin
            if (s1_adv) begin
                s2_valid   <= 1'b1;
                out_result <= fine_data;
                out_tag    <= s1_tag;
                out_err    <= s1_err;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    // Status outputs.
    always_comb begin
        out_valid = s2_valid;
        busy      = s1_valid || s2_valid;
    end

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed self-checking bench for shift_exec_stage.
module tb_shift_exec_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_tag;
    logic        out_err;
    logic        busy;

    int errors = 0;
    int checks = 0;

    shift_exec_stage #(.WIDTH(32), .SHAMT_W(5), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .out_err(out_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    logic [1:0]  v_op  [8];
    logic [31:0] v_a   [8];
    logic [31:0] v_b   [8];
    logic [31:0] v_exp [8];
    int          acc;

    initial begin
        v_op[0] = 2'b00; v_a[0] = 32'h0000_0001; v_b[0] = 32'd0;  v_exp[0] = 32'h0000_0001;
        v_op[1] = 2'b00; v_a[1] = 32'h0000_00FF; v_b[1] = 32'd8;  v_exp[1] = 32'h0000_FF00;
        v_op[2] = 2'b01; v_a[2] = 32'hF000_0000; v_b[2] = 32'd28; v_exp[2] = 32'h0000_000F;
        v_op[3] = 2'b10; v_a[3] = 32'h8000_0000; v_b[3] = 32'd31; v_exp[3] = 32'hFFFF_FFFF;
        v_op[4] = 2'b10; v_a[4] = 32'h7FFF_FFFF; v_b[4] = 32'd30; v_exp[4] = 32'h0000_0001;
        v_op[5] = 2'b00; v_a[5] = 32'h0000_0003; v_b[5] = 32'd33; v_exp[5] = 32'h0000_0006;
        v_op[6] = 2'b01; v_a[6] = 32'h1234_5678; v_b[6] = 32'd12; v_exp[6] = 32'h0001_2345;
        v_op[7] = 2'b10; v_a[7] = 32'hF000_0000; v_b[7] = 32'd4;  v_exp[7] = 32'hFF00_0000;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00;
        in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;

        // Reset state
        step(); step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", out_result, 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // SLL by 31, latency two cycles
        issue(2'b00, 32'h0000_0001, 32'd31, 4'd1);
        step(); idle();
        chk("t1_not_yet", 32'(out_valid), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        step();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_result", out_result, 32'h8000_0000);
        chk("t1_tag", 32'(out_tag), 32'd1);
        step();
        chk("t1_drained", 32'(out_valid), 32'd0);

        // SRA vs SRL with upper b bits set
        issue(2'b10, 32'h8000_0000, 32'h24, 4'd2);
        step();
        issue(2'b01, 32'h8000_0000, 32'h24, 4'd3);
        step(); idle();
        chk("t2_sra", out_result, 32'hF800_0000);
        chk("t2_sra_tag", 32'(out_tag), 32'd2);
        step();
        chk("t2_srl", out_result, 32'h0800_0000);
        chk("t2_srl_tag", 32'(out_tag), 32'd3);
        step();

        // Back-to-back stream of 8 ops
        for (int c = 0; c < 10; c++) begin
            if (c < 8) issue(v_op[c], v_a[c], v_b[c], 4'(c + 4));
            else idle();
            #1;
            if (c < 8) chk($sformatf("t3_in_ready_%0d", c), 32'(in_ready), 32'd1);
            if (c >= 2) begin
                chk($sformatf("t3_valid_%0d", c - 2), 32'(out_valid), 32'd1);
                chk($sformatf("t3_result_%0d", c - 2), out_result, v_exp[c - 2]);
                chk($sformatf("t3_tag_%0d", c - 2), 32'(out_tag), 32'(c + 2));
            end
            step();
        end
        chk("t3_drained", 32'(out_valid), 32'd0);

        // Backpressure: 5 stalled cycles with a stream applied
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            case (acc)
                0: issue(2'b00, 32'h0000_0001, 32'd4, 4'd10);
                1: issue(2'b01, 32'h0000_0F00, 32'd8, 4'd11);
                default: issue(2'b00, 32'h0000_0001, 32'd16, 4'd12);
            endcase
            #1;
            chk($sformatf("t4_in_ready_%0d", c), 32'(in_ready), (c < 2) ? 32'd1 : 32'd0);
            if (c >= 2) begin
                chk($sformatf("t4_hold_valid_%0d", c), 32'(out_valid), 32'd1);
                chk($sformatf("t4_hold_result_%0d", c), out_result, 32'h0000_0010);
                chk($sformatf("t4_hold_tag_%0d", c), 32'(out_tag), 32'd10);
            end
            if (in_valid && in_ready) acc++;
            step();
        end
        chk("t4_accepted", 32'(acc), 32'd2);
        out_ready = 1'b1;
        issue(2'b00, 32'h0000_0001, 32'd16, 4'd12);
        #1;
        chk("t4_release_ready", 32'(in_ready), 32'd1);
        chk("t4_out_a", out_result, 32'h0000_0010);
        step(); idle();
        chk("t4_out_b_valid", 32'(out_valid), 32'd1);
        chk("t4_out_b", out_result, 32'h0000_000F);
        chk("t4_out_b_tag", 32'(out_tag), 32'd11);
        step();
        chk("t4_out_c_valid", 32'(out_valid), 32'd1);
        chk("t4_out_c", out_result, 32'h0001_0000);
        chk("t4_out_c_tag", 32'(out_tag), 32'd12);
        step();
        chk("t4_no_dup", 32'(out_valid), 32'd0);

        // Illegal op passes through with error flag
        issue(2'b11, 32'h1234_5678, 32'd5, 4'd7);
        step(); idle();
        step();
        chk("t5_valid", 32'(out_valid), 32'd1);
        chk("t5_result", out_result, 32'h1234_5678);
        chk("t5_err", 32'(out_err), 32'd1);
        chk("t5_tag", 32'(out_tag), 32'd7);
        step();

        // Reset with a full stalled pipe
        out_ready = 1'b0;
        issue(2'b00, 32'h0000_0001, 32'd1, 4'd8);
        step();
        issue(2'b00, 32'h0000_0001, 32'd2, 4'd9);
        step(); idle();
        chk("t6_full_busy", 32'(busy), 32'd1);
        chk("t6_full_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_result", out_result, 32'd0);
        chk("t6_rst_err", 32'(out_err), 32'd0);

        // Flush with a full stalled pipe and a competing input
        issue(2'b00, 32'h0000_0001, 32'd3, 4'd8);
        step();
        issue(2'b00, 32'h0000_0001, 32'd5, 4'd9);
        step();
        flush = 1'b1;
        issue(2'b00, 32'h0000_00FF, 32'd0, 4'd14);
        #1;
        chk("t6_flush_in_ready", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0; idle();
        chk("t6_flush_valid", 32'(out_valid), 32'd0);
        chk("t6_flush_busy", 32'(busy), 32'd0);
        step();
        chk("t6_flush_no_ghost", 32'(busy), 32'd0);

        // First op after flush is the first result seen
        out_ready = 1'b1;
        issue(2'b01, 32'h0000_0080, 32'd7, 4'd5);
        step(); idle();
        chk("t6_next_pending", 32'(out_valid), 32'd0);
        step();
        chk("t6_next_valid", 32'(out_valid), 32'd1);
        chk("t6_next_result", out_result, 32'h0000_0001);
        chk("t6_next_tag", 32'(out_tag), 32'd5);
        step();
        chk("t6_next_drained", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
